cla_word_sequencer: RTL
=======================

// Module: cla_word_sequencer
// PURPOSE
//   Multi-cycle WIDTH-bit adder/subtractor built on one instance of the 4-bit
//   carry-lookahead adder (cla). Operands are latched, then one nibble per
//   cycle is passed through the cla, LSB nibble first. The carry is held in a
//   register between nibbles.
//   Sits between a requester (valid/ready in) and a consumer (valid/ready out).
//   It is the area-saving alternative to a full-width parallel adder.
// PARAMETERS
//   WIDTH  16  operand/result width; must be a multiple of 4 and >= 8; NIB = WIDTH/4
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      request operands present
//   in_ready   out  1      block can accept a request (= state IDLE)
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry-in for add; ignored when in_sub=1
//   in_sub     in   1      1: A - B (A + ~B + 1); 0: A + B + in_cin
//   out_valid  out  1      result valid; held until out_ready
//   out_ready  in   1      consumer accepts result
//   out_sum    out  WIDTH  result, modulo 2^WIDTH
//   out_cout   out  1      carry out of MSB (sub: 1 = no borrow)
//   out_ovf    out  1      signed overflow = C[4]^C[3] of final nibble
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   - FSM states: IDLE -> RUN -> DONE -> IDLE.
//   - Reset (rst_n low, takes effect immediately):
//       state=IDLE, nibble index=0, carry reg=0, operand regs=0;
//       out_sum=0, out_cout=0, out_ovf=0, out_valid=0, busy=0.
//       in_ready=1 while in reset, but in_valid is ignored until rst_n is high.
//   - IDLE: when in_valid and in_ready are both 1 at edge e0:
//       latch in_a; latch B_eff = in_sub ? ~in_b : in_b;
//       latch carry = in_sub ? 1 : in_cin; clear index; go to RUN.
//   - RUN: the cla is fed A_lat[4k+3:4k], B_eff[4k+3:4k] and the carry reg.
//       At edge e0+k+1, S is written to out_sum[4k+3:4k] and C[4] to the carry reg.
//       At the last nibble (k=NIB-1) the same edge also writes:
//       out_cout=C[4], out_ovf=C[4]^C[3]; state -> DONE.
//   - Latency: out_valid is 1 in the cycle after edge e0+NIB (4 cycles for WIDTH=16).
//   - DONE: out_valid=1. out_sum, out_cout and out_ovf are stable until the
//       out_ready handshake. On out_valid&&out_ready go to IDLE; out_valid drops next cycle.
//   - Throughput: in_ready=0 in RUN and DONE, so there is no overlap.
//       The minimum request spacing is NIB+2 cycles.
//   - Input changes during RUN/DONE are ignored; operands are latched at accept.
//   - out_sum is partially updated during RUN and is meaningful only when out_valid=1.
//   - Reset asserted mid-RUN or in DONE: abort with no output handshake.
//       All registers return to their reset values.
//   - Index wraps only via the RUN->DONE transition; it never exceeds NIB-1.
// TESTING
//   1. Add: A=0x1234, B=0x0FCD, cin=0, sub=0 -> sum=0x2201, cout=0, ovf=0;
//      out_valid 4 cycles after accept.
//   2. Full ripple: 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
//      0xFFFE+0x0000, cin=1 -> sum=0xFFFF, cout=0.
//   3. Signed overflow: 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
//   4. Subtract: 0x0005-0x0007 -> 0xFFFE, cout=0, ovf=0.
//      0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.
//   5. Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1
//      -> outputs held, in_ready=0, no second accept.
//      Then out_ready=1 -> IDLE, and the new request is accepted the next cycle.
//   6. Reset after 2 RUN nibbles -> out_valid never rises, busy=0, in_ready=1.
//      A following 0x00FF+0x0001 returns 0x0100.
//      Repeat tests 1-3 with WIDTH=8.

Source files
------------

// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: a WIDTH-bit adder/subtractor that runs one nibble per
// cycle through a single 4-bit carry-lookahead adder. The least significant
// nibble goes first, and the carry is held in a register between nibbles.
// Operands are latched when the request is accepted. The result is held until
// the consumer takes it.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   request can be accepted (state IDLE)
//   in_a/in_b  WIDTH-bit operands
//   in_cin     carry-in for add (ignored when subtracting)
//   in_sub     1: A - B, 0: A + B + in_cin
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   out_sum    result modulo 2^WIDTH
//   out_cout   carry out of the MSB (subtract: 1 = no borrow)
//   out_ovf    signed overflow of the final nibble
//   busy       operation in progress or result waiting

// 4-bit carry-lookahead adder. It exposes the carries into and out of bit 3,
// so the caller can derive signed overflow.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       c4
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign c3   = c[3];
  assign s    = p ^ c;
endmodule

module cla_word_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [IW-1:0]    idx_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             cout_reg, ovf_reg;

  logic [3:0] nib_a [NIB];
  logic [3:0] nib_b [NIB];
  logic [3:0] cla_a, cla_b, cla_s;
  logic       cla_c3, cla_c4;
  logic       accept, run_step;

  // Split the latched operands into nibbles. The current index selects the
  // pair that feeds the adder.
  generate
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
      assign nib_a[gi] = a_reg[4*gi +: 4];
      assign nib_b[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

  assign cla_a = nib_a[idx_reg];
  assign cla_b = nib_b[idx_reg];

  cla u_cla (
    .a  (cla_a),
    .b  (cla_b),
    .ci (carry_reg),
    .s  (cla_s),
    .c3 (cla_c3),
    .c4 (cla_c4)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)         state_next = RUN;
      RUN:     if (idx_reg == LAST)  state_next = DONE;
      DONE:    if (out_ready)        state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready  = (state_reg == IDLE);
    busy      = (state_reg != IDLE);
    out_valid = (state_reg == DONE);
    accept    = in_valid && (state_reg == IDLE);
    run_step  = (state_reg == RUN);
  end

  // Datapath. Subtraction is done as A + ~B + 1: B is inverted once, at
  // accept time, and the seed carry is forced to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= in_a;
      b_reg     <= in_sub ? ~in_b : in_b;
      carry_reg <= in_sub | in_cin;
      idx_reg   <= '0;
    end else if (run_step) begin
      carry_reg <= cla_c4;
      for (int i = 0; i < NIB; i++) begin
        if (idx_reg == IW'(i)) sum_reg[4*i +: 4] <= cla_s;
      end
      if (idx_reg == LAST) begin
        // The index wraps here, and only here.
        idx_reg  <= '0;
        cout_reg <= cla_c4;
        ovf_reg  <= cla_c4 ^ cla_c3;
      end else begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  assign out_sum  = sum_reg;
  assign out_cout = cout_reg;
  assign out_ovf  = ovf_reg;
endmodule
